// File: rtl/conv2d_stream_sequencer_if.sv
// AXI-Stream style bundle shared by the upstream and downstream ports of
// conv2d_stream_sequencer.
interface conv2d_stream_sequencer_if #(
   parameter int unsigned DATA_W = 16
) ();
   logic [DATA_W-1:0]   TDATA;
   logic [DATA_W/8-1:0] TKEEP;
   logic                TLAST;
   logic                TVALID;
   logic                TREADY;

   modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
   modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/conv2d_stream_sequencer.sv
// Feeds conv2D one weight kernel then one zero-padded feature map, framing each with TLAST.
// Optional upstream TLAST checking is enabled by defining CONV2D_SEQ_TLAST_CHECK_EN.
module conv2d_stream_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned TAPS   = 9,
   parameter int unsigned IMG_H  = 2,
   parameter int unsigned IMG_W  = 5
) (
   input  logic ACLK,
   input  logic ARESET,
   input  logic START,
   output logic BUSY,
   output logic DONE,
   output logic ERR,
   conv2d_stream_sequencer_if.slave  S_AXIS,
   conv2d_stream_sequencer_if.master M_AXIS
);
   localparam int unsigned WW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int unsigned RW = $clog2(IMG_H + 1);
   localparam int unsigned CW = $clog2(IMG_W + 2);

   localparam logic [WW-1:0] W_LAST = WW'(TAPS - 1);
   localparam logic [RW-1:0] R_PAD  = RW'(IMG_H);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WGT, S_COL_PRE, S_PAD_TOP, S_PIX, S_COL_POST, S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [WW-1:0]     wgt_cnt_q, wgt_cnt_d;
   logic [RW-1:0]     row_cnt_q, row_cnt_d;
   logic [CW-1:0]     col_cnt_q, col_cnt_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic              m_valid_q, m_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              can_load;
   logic              s_ready;
   logic              s_accept;
   logic              unused_in;

   assign can_load = !m_valid_q || M_AXIS.TREADY;
   assign s_ready  = ((state_q == S_WGT) || (state_q == S_PIX)) && can_load;
   assign s_accept = s_ready && S_AXIS.TVALID;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         wgt_cnt_q <= '0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wgt_cnt_q <= wgt_cnt_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // The output register empties on a downstream handshake unless a state below refills it.
   always_comb begin
      state_d   = state_q;
      wgt_cnt_d = wgt_cnt_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q && !can_load;
      m_valid_d = m_valid_q && !can_load;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (START && !done_q) begin
               state_d   = S_WGT;
               busy_d    = 1'b1;
               wgt_cnt_d = '0;
            end
         end
         S_WGT: begin
            if (s_accept) begin
               m_valid_d = 1'b1;
               m_data_d  = S_AXIS.TDATA;
               m_last_d  = (wgt_cnt_q == W_LAST);
               if (wgt_cnt_q == W_LAST) begin
                  state_d   = S_COL_PRE;
                  row_cnt_d = '0;
               end else begin
                  wgt_cnt_d = wgt_cnt_q + WW'(1);
               end
            end
         end
         S_COL_PRE: begin
            if (can_load) begin
               m_valid_d = 1'b1;
               m_data_d  = '0;
               m_last_d  = 1'b0;
               if (row_cnt_q == R_PAD) begin
                  state_d   = S_PAD_TOP;
                  row_cnt_d = '0;
                  col_cnt_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         S_PAD_TOP: begin
            if (can_load) begin
               m_valid_d = 1'b1;
               m_data_d  = '0;
               m_last_d  = 1'b0;
               state_d   = S_PIX;
               row_cnt_d = '0;
            end
         end
         S_PIX: begin
            if (s_accept) begin
               m_valid_d = 1'b1;
               m_data_d  = S_AXIS.TDATA;
               m_last_d  = 1'b0;
               if (row_cnt_q == R_LAST) begin
                  row_cnt_d = '0;
                  if (col_cnt_q == C_LAST) begin
                     state_d = S_COL_POST;
                  end else begin
                     state_d   = S_PAD_TOP;
                     col_cnt_d = col_cnt_q + CW'(1);
                  end
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         S_COL_POST: begin
            if (can_load) begin
               m_valid_d = 1'b1;
               m_data_d  = '0;
               m_last_d  = (row_cnt_q == R_PAD);
               if (row_cnt_q == R_PAD) begin
                  state_d   = S_FIN;
                  row_cnt_d = '0;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         S_FIN: begin
            if (m_valid_q && M_AXIS.TREADY) begin
               state_d   = S_IDLE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               col_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CONV2D_SEQ_TLAST_CHECK_EN
   logic err_q, err_d;
   logic at_end;

   always_comb begin
      at_end = ((state_q == S_WGT) && (wgt_cnt_q == W_LAST)) ||
               ((state_q == S_PIX) && (row_cnt_q == R_LAST) && (col_cnt_q == C_LAST));
      err_d  = err_q;
      if (s_accept && (S_AXIS.TLAST != at_end)) err_d = 1'b1;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

   assign unused_in = ^{S_AXIS.TKEEP, S_AXIS.TLAST};

   assign S_AXIS.TREADY = s_ready;
   assign M_AXIS.TDATA  = m_data_q;
   assign M_AXIS.TKEEP  = '1;
   assign M_AXIS.TLAST  = m_last_q;
   assign M_AXIS.TVALID = m_valid_q;
   assign BUSY          = busy_q;
   assign DONE          = done_q;
endmodule

// File: tb/tb_conv2d_stream_sequencer.sv
// Directed scoreboard bench for conv2d_stream_sequencer (default geometry 9 taps, 2x5 image).
module tb_conv2d_stream_sequencer;
   logic ACLK;
   logic ARESET;
   logic START;
   logic BUSY;
   logic DONE;
   logic ERR;

   conv2d_stream_sequencer_if #(.DATA_W(16)) s_if ();
   conv2d_stream_sequencer_if #(.DATA_W(16)) m_if ();

   conv2d_stream_sequencer #(
      .DATA_W(16), .TAPS(9), .IMG_H(2), .IMG_W(5)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .START(START),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .S_AXIS(s_if.slave), .M_AXIS(m_if.master)
   );

`ifdef CONV2D_SEQ_TLAST_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   int unsigned      vectors = 0;
   int unsigned      miscompares = 0;
   int unsigned      hs_cnt = 0;
   int unsigned      done_cnt = 0;
   bit               rdy_mode = 0;
   logic [31:0]      exp_q[$];
   bit               held = 0;
   logic [31:0]      hold_word;

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Downstream ready: steady high, or toggling every cycle in rdy_mode 1.
   initial begin
      m_if.TREADY = 1'b1;
      forever begin
         @(posedge ACLK);
         #1;
         m_if.TREADY = rdy_mode ? ~m_if.TREADY : 1'b1;
      end
   end

   // Output monitor: pops the scoreboard on each handshake, checks hold stability under backpressure.
   always @(negedge ACLK) begin
      if (ARESET) begin
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", {31'd0, m_if.TVALID}, 32'd1);
            chk("hold_word", {15'd0, m_if.TLAST, m_if.TDATA}, hold_word);
            held = 0;
         end
         if (m_if.TVALID && m_if.TREADY) begin
            hs_cnt++;
            chk("tkeep", {30'd0, m_if.TKEEP}, 32'd3);
            if (exp_q.size() == 0)
               chk("unexpected_word", {15'd0, m_if.TLAST, m_if.TDATA}, 32'hFFFF_FFFF);
            else
               chk("word", {15'd0, m_if.TLAST, m_if.TDATA}, exp_q.pop_front());
         end else if (m_if.TVALID) begin
            held = 1;
            hold_word = {15'd0, m_if.TLAST, m_if.TDATA};
         end
         if (DONE) done_cnt++;
      end
   end

   function automatic logic [15:0] pix_val(input int unsigned idx);
      return 16'((idx / 2) + 1 + 5 * (idx % 2));
   endfunction

   task automatic push_expected();
      for (int unsigned i = 0; i < 9; i++) exp_q.push_back({15'd0, (i == 8), 16'(i + 1)});
      for (int unsigned i = 0; i < 3; i++) exp_q.push_back(32'd0);
      for (int unsigned c = 0; c < 5; c++) begin
         exp_q.push_back(32'd0);
         exp_q.push_back({16'd0, pix_val(2 * c)});
         exp_q.push_back({16'd0, pix_val(2 * c + 1)});
      end
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back({15'd0, 1'b1, 16'd0});
   endtask

   task automatic pulse_start();
      @(posedge ACLK);
      #2 START = 1'b1;
      @(posedge ACLK);
      #2 START = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      s_if.TVALID = 1'b0;
      repeat (n) @(posedge ACLK);
      #2;
   endtask

   task automatic send_word(input logic [15:0] d, input logic l, input bit st);
      int unsigned n = 0;
      bit ok = 0;
      s_if.TDATA  = d;
      s_if.TLAST  = l;
      s_if.TVALID = 1'b1;
      if (st) START = 1'b1;
      while (!ok && n < 200) begin
         @(negedge ACLK);
         if (s_if.TREADY) ok = 1;
         @(posedge ACLK);
         #2;
         n++;
      end
      s_if.TVALID = 1'b0;
      START = 1'b0;
      if (!ok) chk("upstream_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int unsigned d0);
      int unsigned n = 0;
      bit seen = 0;
      while (!seen && n < 400) begin
         @(negedge ACLK);
         #1;
         if (DONE) seen = 1;
         n++;
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      chk("busy_falls_with_done", {31'd0, BUSY}, 32'd0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      START = 1'b1;
      @(posedge ACLK);
      #2 START = 1'b0;
      @(negedge ACLK);
      #1;
      chk("start_with_done_ignored", {31'd0, BUSY}, 32'd0);
      chk("done_single_pulse", {31'd0, DONE}, 32'd0);
      chk("done_count", done_cnt - d0, 32'd1);
   endtask

   task automatic run_seq(input bit bubbles, input bit w5_last, input bit restart_mid);
      int unsigned d0 = done_cnt;
      push_expected();
      pulse_start();
      for (int unsigned i = 0; i < 9; i++) begin
         if (bubbles && i == 4) idle(3);
         send_word(16'(i + 1), (i == 8) || (w5_last && i == 4), 1'b0);
      end
      for (int unsigned k = 0; k < 10; k++) begin
         if (bubbles && k == 5) idle(3);
         send_word(pix_val(k), (k == 9), restart_mid && (k == 3));
      end
      wait_done(d0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},   {31'd0, BUSY}, 32'd0);
      chk({tag, "_done"},   {31'd0, DONE}, 32'd0);
      chk({tag, "_err"},    {31'd0, ERR}, 32'd0);
      chk({tag, "_mvalid"}, {31'd0, m_if.TVALID}, 32'd0);
      chk({tag, "_mlast"},  {31'd0, m_if.TLAST}, 32'd0);
      chk({tag, "_mdata"},  {16'd0, m_if.TDATA}, 32'd0);
      chk({tag, "_sready"}, {31'd0, s_if.TREADY}, 32'd0);
   endtask

   initial begin
      int unsigned base;
      int unsigned n;
      ARESET = 1'b1;
      START = 1'b0;
      s_if.TDATA = '0;
      s_if.TKEEP = '0;
      s_if.TLAST = 1'b0;
      s_if.TVALID = 1'b0;
      repeat (3) @(negedge ACLK);
      check_reset_outputs("reset");
      @(posedge ACLK);
      #2 ARESET = 1'b0;

      run_seq(0, 0, 0);
      chk("err_clean_seq", {31'd0, ERR}, 32'd0);

      rdy_mode = 1;
      run_seq(0, 0, 0);
      rdy_mode = 0;

      run_seq(1, 0, 0);
      run_seq(0, 0, 1);
      run_seq(0, 1, 0);
      chk("err_after_bad_tlast", {31'd0, ERR}, {31'd0, ERR_EXP});
      run_seq(0, 0, 0);
      chk("err_sticky", {31'd0, ERR}, {31'd0, ERR_EXP});

      // Abort near frame word 10, then restart from weight 0.
      base = hs_cnt;
      push_expected();
      pulse_start();
      for (int unsigned i = 0; i < 9; i++) send_word(16'(i + 1), (i == 8), 1'b0);
      for (int unsigned k = 0; k < 4; k++) send_word(pix_val(k), 1'b0, 1'b0);
      n = 0;
      while (hs_cnt < base + 19 && n < 100) begin
         @(negedge ACLK);
         #1;
         n++;
      end
      chk("abort_reached_word10", {31'd0, (hs_cnt >= base + 19)}, 32'd1);
      @(posedge ACLK);
      #2 ARESET = 1'b1;
      @(negedge ACLK);
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      @(posedge ACLK);
      #2 ARESET = 1'b0;
      run_seq(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/conv2d_stream_sequencer.md
# conv2d_stream_sequencer

Sequences the AXI-Stream feed into `conv2D`: on `START` it forwards one kernel of weights, then one padded feature map, and frames each phase with TLAST exactly as `conv2D` expects. It sits between the DMA/upstream stream and the `conv2D` slave port. It inserts the zero padding words itself, so upstream sends only raw weights and raw pixels.

## Interface
- `DATA_W`, 16, stream word width; TKEEP width is DATA_W/8
- `TAPS`, 9, weight words per kernel
- `IMG_H`, 2, image rows (pixels per column, unpadded)
- `IMG_W`, 5, image columns (unpadded)

- `ACLK`  in  1  clock
- `ARESET`  in  1  reset; one clock, asynchronous, active-high
- `START`  in  1  one-cycle pulse begins a weight+frame sequence
- `BUSY`  out  1  high from accepted START until DONE
- `DONE`  out  1  one-cycle pulse after the last frame word handshakes downstream
- `ERR`  out  1  sticky upstream TLAST misalignment flag (see Configuration)
- `S_AXIS_TDATA`  in  DATA_W  upstream weights, then pixels in column-major order
- `S_AXIS_TKEEP`  in  DATA_W/8  ignored
- `S_AXIS_TLAST`  in  1  upstream end-of-phase marker
- `S_AXIS_TVALID`  in  1  upstream valid
- `S_AXIS_TREADY`  out  1  upstream ready
- `M_AXIS_TDATA`  out  DATA_W  word to conv2D
- `M_AXIS_TKEEP`  out  DATA_W/8  all ones
- `M_AXIS_TLAST`  out  1  last word of the weight phase or the frame phase
- `M_AXIS_TVALID`  out  1  downstream valid
- `M_AXIS_TREADY`  in  1  conv2D ready

## Operation
- States: IDLE, WGT, COL_PRE, PAD_TOP, PIX, COL_POST, FIN.
- IDLE: `START` moves to WGT and sets BUSY. `START` in any other state is ignored.
- WGT: passes TAPS upstream words. The TLAST bit is set on word TAPS-1 regardless of upstream TLAST. Then goes to COL_PRE.
- COL_PRE: emits IMG_H+1 zero words (left pad column).
- PAD_TOP: emits one zero word per image column, then goes to PIX.
- PIX: passes IMG_H upstream words. After column IMG_W-1 goes to COL_POST; otherwise returns to PAD_TOP.
- COL_POST: emits IMG_H+1 zero words. TLAST is set on the final word.
- FIN: waits for the last word to handshake, pulses DONE, clears BUSY, returns to IDLE.
- Frame length is (IMG_W+2)*(IMG_H+1) words. With defaults that is 21.
- Output stage: a single register. It loads when `!M_AXIS_TVALID || M_AXIS_TREADY`.
- `S_AXIS_TREADY` = (state is WGT or PIX) && output stage can load. Upstream is never accepted in any other state.
- Pad words are generated only when the output stage can load.
- Counters: weight counter is $clog2(TAPS) bits; row counter is $clog2(IMG_H+1) bits; column counter is $clog2(IMG_W+2) bits. Each counter clears on phase entry. No data arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: BUSY=0, DONE=0, ERR=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0. State is IDLE and all counters are 0.
- `ARESET` mid-sequence aborts immediately with no flush. A partially sent word is dropped.
- Latency: a word accepted upstream on edge N appears on M_AXIS at edge N. It is visible during cycle N+1.
- Throughput: one word per cycle under continuous TVALID/TREADY.
- With no stalls, the first weight word appears 2 cycles after START. The frame starts the cycle after the weight TLAST word loads.
- Downstream backpressure holds M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TVALID stable. S_AXIS_TREADY drops in the same cycle.
- Upstream bubbles (TVALID=0 in WGT/PIX) cause M_AXIS_TVALID=0 bubbles. The state does not advance.
- DONE asserts the cycle after the frame-TLAST handshake. BUSY falls with DONE.
- START coincident with DONE is ignored.

## Configuration
- Macro: `CONV2D_SEQ_TLAST_CHECK_EN`.
- Defined: ERR sets, and stays set until ARESET, in either of two cases:
  - an upstream word accepted with S_AXIS_TLAST=1 that is not weight TAPS-1 or the final pixel;
  - weight TAPS-1 or the final pixel accepted with S_AXIS_TLAST=0.
- Defined: sequencing is unaffected by ERR.
- Undefined: ERR is tied 0 and upstream TLAST is ignored entirely.

## Test plan
- Defaults, M_TREADY=1, upstream weights 1..9 then pixels 1,6,2,7,3,8,4,9,5,10 → M stream 1..9 with TLAST on 9, then 0,0,0, 0,1,6, 0,2,7, 0,3,8, 0,4,9, 0,5,10, 0,0,0 with TLAST only on the 21st word. DONE pulses once.
- Same stimulus with M_TREADY toggled 1,0 every cycle → identical 30-word sequence. No word is lost or duplicated, and data is stable while TREADY=0.
- Upstream TVALID dropped for 3 cycles mid-weights and mid-column 3 → output has bubbles only and the sequence is unchanged.
- START pulsed again during the frame → ignored. One DONE, then a second START runs a full new sequence.
- ARESET asserted at frame word 10 → all outputs return to reset values on the next sample. A following START restarts from weight 0.
- With CONV2D_SEQ_TLAST_CHECK_EN, upstream TLAST on weight 5 → ERR=1 and held, output sequence unchanged. Without the macro, ERR stays 0.
